timer_initiator: RTL and testbench
==================================

TIMER_INITIATOR -- requirements
Module: timer_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, width of the WAIT_IRQ timeout counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at posedge.
REQ-006 SHALL have port cmd_op  input  2  00 WRITE, 01 READ, 10 WAIT_IRQ, 11 reserved.
REQ-007 SHALL have port cmd_addr  input  3  timer register address (A[2]=irq enable, A[1:0]=prescale / A[0]=read select).
REQ-008 SHALL have port cmd_wdata  input  8  write data (load value for WRITE).
REQ-009 SHALL have port cmd_timeout  input  TIMEOUT_W  WAIT_IRQ limit in clocks; 0 = wait forever.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed when rsp_valid&rsp_ready at posedge.
REQ-012 SHALL have port rsp_data  output  8  read data; 0x00 for WRITE, WAIT_IRQ and errors.
REQ-013 SHALL have port rsp_err  output  1  1 = timeout or reserved op.
REQ-014 SHALL have port enable  output  1  timer chip select.
REQ-015 SHALL have port we_n  output  1  0 = write, 1 = read.
REQ-016 SHALL have port A  output  3  timer address.
REQ-017 SHALL have port DI  output  8  write data to timer.
REQ-018 SHALL have port DO  input  8  read data from timer.
REQ-019 SHALL have port OE  input  1  timer drives DO.
REQ-020 SHALL have port irq  input  1  timer interrupt, active-low.

Function
REQ-021 SHALL implement states IDLE, WR, RD1, RD2, WAIT, RESP.
REQ-022 SHALL assert cmd_ready only in IDLE; one command outstanding at a time.
REQ-023 SHALL latch cmd_op, cmd_addr, cmd_wdata, cmd_timeout on acceptance; IDLE->WR/RD1/WAIT/RESP(err) by op.
REQ-024 SHALL in WR drive enable=1, we_n=0, A=latched addr, DI=latched data for exactly one clock, then ->RESP.
REQ-025 SHALL in RD1 and RD2 drive enable=1, we_n=1, A=latched addr, one clock each; capture DO at the RD2->RESP edge.
REQ-026 SHALL set rsp_err=1 and rsp_data=0x00 if OE=0 at the RD2 capture edge.
REQ-027 SHALL keep enable=0, we_n=1, A=0, DI=0 in IDLE, WAIT and RESP.
REQ-028 SHALL in WAIT count clocks from 0; ->RESP rsp_err=0 when irq=0 is sampled; ->RESP rsp_err=1 when count reaches cmd_timeout (nonzero).
REQ-029 SHALL give irq=0 priority over timeout when both occur on the same edge.
REQ-030 SHALL, for WAIT_IRQ with irq already 0 at acceptance, respond in the first WAIT cycle.
REQ-031 SHALL for reserved op go directly to RESP with rsp_err=1, no bus cycle.
REQ-032 SHALL hold rsp_valid=1 with stable rsp_data/rsp_err in RESP until rsp_ready; then ->IDLE.
REQ-033 SHALL give latency: WRITE accept->rsp_valid 2 clocks, READ 3 clocks, reserved 1 clock.
REQ-034 SHALL not saturate the WAIT counter; with cmd_timeout=0 it wraps freely.

Reset
REQ-035 SHALL on rst_n=0 immediately force IDLE, cmd_ready=0, rsp_valid=0, rsp_data=0x00, rsp_err=0, enable=0, we_n=1, A=0, DI=0, counter=0.
REQ-036 SHALL abort any bus cycle or wait in progress on reset, with no response issued.
REQ-037 SHALL assert cmd_ready in the first clock after rst_n deasserts.

Structure
REQ-038 SHALL place op codes, state enum and the bus idle values in shared package timer_pkg.
REQ-039 SHALL be a single module, no sub-modules.

Verification
REQ-040 SHALL cover WRITE addr=3'b101 data=0x10 -> one clock of enable=1, we_n=0, A=5, DI=0x10; rsp_valid 2 clocks after accept, rsp_err=0.
REQ-041 SHALL cover READ addr=0 against a timer model returning 0x0F -> enable high 2 clocks, rsp_data=0x0F, rsp_err=0.
REQ-042 SHALL cover WAIT_IRQ timeout=100 with irq dropping at clock 40 -> rsp_err=0 at clock 40; repeat with irq held high -> rsp_err=1 at clock 100.
REQ-043 SHALL cover reserved op 11 -> rsp_err=1 after 1 clock, enable never asserted.
REQ-044 SHALL cover rsp_ready held low for 5 clocks -> rsp_valid and rsp_data stable, cmd_ready=0 throughout.
REQ-045 SHALL cover rst_n low during RD1 -> enable=0 and state IDLE asynchronously, no response afterwards.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared op codes, FSM state encoding and idle bus levels for the timer initiator.
package timer_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_READ     = 2'b01,
    OP_WAIT_IRQ = 2'b10,
    OP_RSVD     = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    WAIT = 3'd4,
    RESP = 3'd5
  } state_t;

  localparam logic       BUS_IDLE_ENABLE = 1'b0;
  localparam logic       BUS_IDLE_WE_N   = 1'b1;
  localparam logic [2:0] BUS_IDLE_A      = 3'b000;
  localparam logic [7:0] BUS_IDLE_DI     = 8'h00;

endpackage

// File: rtl/timer_initiator.sv
// Turns WRITE / READ / WAIT_IRQ commands into timer bus cycles, one response per command.
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   WR    | one-clock write strobe on the timer bus
//   RD1   | first read clock, timer drives DO
//   RD2   | second read clock, DO/OE captured on exit
//   WAIT  | waiting for irq low or timeout
//   RESP  | response held until rsp_ready
module timer_initiator
  import timer_pkg::*;
#(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [2:0]           cmd_addr,
  input  logic [7:0]           cmd_wdata,
  input  logic [TIMEOUT_W-1:0] cmd_timeout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 enable,
  output logic                 we_n,
  output logic [2:0]           A,
  output logic [7:0]           DI,
  input  logic [7:0]           DO,
  input  logic                 OE,
  input  logic                 irq
);

  state_t               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  op_t                  op_q, op_d;
  logic [2:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic [7:0]           rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 bus_active;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + 1'b1;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = op_t'(cmd_op);
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          timeout_d  = cmd_timeout;
          cnt_d      = '0;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b0;
          case (op_t'(cmd_op))
            OP_WRITE:    state_d = WR;
            OP_READ:     state_d = RD1;
            OP_WAIT_IRQ: state_d = WAIT;
            OP_RSVD: begin
              state_d   = RESP;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      WR:  state_d = RESP;
      RD1: state_d = RD2;
      RD2: begin
        state_d    = RESP;
        rsp_data_d = OE ? DO : 8'h00;
        rsp_err_d  = ~OE;
      end
      WAIT: begin
        // irq wins over a timeout landing on the same edge; timeout 0 never fires
        if (!irq) begin
          state_d = RESP;
        end else if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      op_q        <= OP_WRITE;
      addr_q      <= 3'b000;
      wdata_q     <= 8'h00;
      timeout_q   <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus_active = (state_q == WR) || (state_q == RD1) || (state_q == RD2);

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign enable    = bus_active ? 1'b1 : BUS_IDLE_ENABLE;
  assign we_n      = bus_active ? (op_q != OP_WRITE) : BUS_IDLE_WE_N;
  assign A         = bus_active ? addr_q : BUS_IDLE_A;
  assign DI        = (state_q == WR) ? wdata_q : BUS_IDLE_DI;

endmodule

// File: tb/tb_timer_initiator.sv
// Directed bench for timer_initiator with a small register-file timer model.
module tb_timer_initiator;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_addr = 3'b000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic [15:0] cmd_timeout = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        enable, we_n;
  logic [2:0]  A;
  logic [7:0]  DI, DO;
  logic        OE;
  logic        irq = 1'b1;
  logic        oe_ok = 1'b1;
  logic [7:0]  regs [8];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  timer_initiator #(.TIMEOUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_timeout(cmd_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .enable(enable), .we_n(we_n), .A(A), .DI(DI), .DO(DO), .OE(OE), .irq(irq)
  );

  // timer model: writes land in regs, reads return regs[A] with OE under bench control
  assign DO = (enable && we_n) ? regs[A] : 8'h00;
  assign OE = enable && we_n && oe_ok;
  always @(posedge clk) if (enable && !we_n) regs[A] <= DI;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  addr;
    logic [7:0]  wd;
    logic [15:0] tmo;
    bit          oe_en;
    int          irq_at;
    int          lat;
    int          en;
    logic [7:0]  data;
    logic        err;
  } vec_t;

  vec_t vecs [13];

  task automatic run_cmd(input vec_t v, input int hold,
                         output int lat, output int en_cyc, output int bus_bad,
                         output int rdy_bad, output int stab_bad,
                         output logic [7:0] data, output logic err);
    int  n;
    bit  got;
    lat = -1; en_cyc = 0; bus_bad = 0; rdy_bad = 0; stab_bad = 0;
    data = 8'hxx; err = 1'bx;
    oe_ok = v.oe_en;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr;
    cmd_wdata = v.wd; cmd_timeout = v.tmo;
    irq = (v.irq_at == 0) ? 1'b0 : 1'b1;
    @(posedge clk);
    got = 1'b0;
    for (int i = 1; i <= 600 && !got; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (cmd_ready) rdy_bad++;
      if (rsp_valid) begin
        got = 1'b1; lat = i; data = rsp_data; err = rsp_err;
      end else begin
        if (enable) begin
          en_cyc++;
          if (A != v.addr || we_n != (v.op != 2'b00) || (v.op == 2'b00 && DI != v.wd))
            bus_bad++;
        end else if (A != 3'b000 || DI != 8'h00 || we_n != 1'b1) begin
          bus_bad++;
        end
        irq = (v.irq_at >= 0 && i >= v.irq_at) ? 1'b0 : 1'b1;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data != data || rsp_err != err || cmd_ready) stab_bad++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    irq = 1'b1;
    @(negedge clk);
    if (rsp_valid || !cmd_ready) rdy_bad++;
  endtask

  initial begin
    int lat, en_cyc, bus_bad, rdy_bad, stab_bad, seen;
    logic [7:0] data;
    logic err;

    for (int r = 0; r < 8; r++) regs[r] = 8'h00;
    regs[0] = 8'h0F;

    //          op     addr  wd     tmo      oe  irq_at lat  en data   err
    vecs[0]  = '{2'b00, 3'd5, 8'h10, 16'd0,   1, -1,    2,   1, 8'h00, 1'b0};
    vecs[1]  = '{2'b01, 3'd0, 8'h00, 16'd0,   1, -1,    3,   2, 8'h0F, 1'b0};
    vecs[2]  = '{2'b01, 3'd5, 8'h00, 16'd0,   1, -1,    3,   2, 8'h10, 1'b0};
    vecs[3]  = '{2'b01, 3'd5, 8'h00, 16'd0,   0, -1,    3,   2, 8'h00, 1'b1};
    vecs[4]  = '{2'b00, 3'd2, 8'hA5, 16'd0,   1, -1,    2,   1, 8'h00, 1'b0};
    vecs[5]  = '{2'b01, 3'd2, 8'h00, 16'd0,   1, -1,    3,   2, 8'hA5, 1'b0};
    vecs[6]  = '{2'b10, 3'd0, 8'h00, 16'd100, 1, 40,    41,  0, 8'h00, 1'b0};
    vecs[7]  = '{2'b10, 3'd0, 8'h00, 16'd100, 1, -1,    101, 0, 8'h00, 1'b1};
    vecs[8]  = '{2'b10, 3'd0, 8'h00, 16'd0,   1, 0,     2,   0, 8'h00, 1'b0};
    vecs[9]  = '{2'b10, 3'd0, 8'h00, 16'd5,   1, 5,     6,   0, 8'h00, 1'b0};
    vecs[10] = '{2'b10, 3'd0, 8'h00, 16'd1,   1, -1,    2,   0, 8'h00, 1'b1};
    vecs[11] = '{2'b11, 3'd7, 8'hFF, 16'd0,   1, -1,    1,   0, 8'h00, 1'b1};
    vecs[12] = '{2'b10, 3'd0, 8'h00, 16'd0,   1, 300,   301, 0, 8'h00, 1'b0};

    // reset values while rst_n is low
    #3;
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_rsp_err", int'(rsp_err), 0);
    check("rst_enable", int'(enable), 0);
    check("rst_we_n", int'(we_n), 1);
    check("rst_A", int'(A), 0);
    check("rst_DI", int'(DI), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", int'(cmd_ready), 1);

    foreach (vecs[k]) begin
      run_cmd(vecs[k], 0, lat, en_cyc, bus_bad, rdy_bad, stab_bad, data, err);
      check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
      check($sformatf("v%0d_rsp_data", k), int'(data), int'(vecs[k].data));
      check($sformatf("v%0d_rsp_err", k), int'(err), int'(vecs[k].err));
      check($sformatf("v%0d_enable_cycles", k), en_cyc, vecs[k].en);
      check($sformatf("v%0d_bus_fields", k), bus_bad, 0);
      check($sformatf("v%0d_ready_handshake", k), rdy_bad, 0);
    end

    // response held for 5 clocks with rsp_ready low
    run_cmd(vecs[1], 5, lat, en_cyc, bus_bad, rdy_bad, stab_bad, data, err);
    check("hold_rsp_data", int'(data), 8'h0F);
    check("hold_stable", stab_bad, 0);
    check("hold_ready_low", rdy_bad, 0);

    // reset asserted in the middle of RD1
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 3'd0; cmd_wdata = 8'h00; cmd_timeout = 16'd0;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    check("rd1_enable_before_rst", int'(enable), 1);
    rst_n = 1'b0;
    #1;
    check("abort_enable", int'(enable), 0);
    check("abort_state_idle", int'(dut.state_q), int'(IDLE));
    check("abort_cmd_ready", int'(cmd_ready), 0);
    check("abort_rsp_valid", int'(rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || enable) seen++;
    end
    check("abort_no_response", seen, 0);
    check("abort_ready_again", int'(cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
